// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver: 2-flop sync, 3-tap majority vote, valid/ready byte output.
// Byte valid the cycle after the stop-bit decision; UART_RX_FIFO_EN swaps the holding register for a 4-deep FIFO.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rxd,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic          sync1, sync2;
    logic [2:0]    hist;
    logic          maj;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_done;
    logic          ferr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 3'b111;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            hist  <= {hist[1:0], sync2};
        end
    end

    assign maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_o <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync2) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    // a start bit that has gone high again by mid-bit is a glitch
                    if (maj) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    shift_d = {maj, shift_q[7:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (maj) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                // hold here so a long break yields a single framing error
                if (sync2) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [2:0] wp_q, rp_q;
    logic       empty, full, push, pop;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[1:0] == rp_q[1:0]) && (wp_q[2] != rp_q[2]);
    assign pop     = !empty && ready_i;
    assign push    = byte_done && (!full || pop);
    assign data_o  = mem[rp_q[1:0]];
    assign valid_o = !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            wp_q      <= '0;
            rp_q      <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= byte_done && full && !pop;
            if (push) begin
                mem[wp_q[1:0]] <= shift_q;
                wp_q           <= wp_q + 3'd1;
            end
            if (pop) begin
                rp_q <= rp_q + 3'd1;
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (byte_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift_q;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
`endif

endmodule
